// File: rtl/traffic_light_ctrl.sv
// Two-way traffic light phase sequencer with 1 Hz prescaler; drives a BCD down-counter (cnt10).
// Define ALLRED_EN to insert all-red clearance phases (AR_A, AR_B) after each yellow.
module traffic_light_ctrl #(
  parameter int unsigned CLK_DIV  = 50_000_000,
  parameter logic [7:0]  GREEN_NS = 8'h30,
  parameter logic [7:0]  GREEN_EW = 8'h25,
  parameter logic [7:0]  YELLOW   = 8'h05,
  parameter logic [7:0]  ALL_RED  = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       cnt_zero,
  output logic       cnt_en,
  output logic       cnt_load,
  output logic [7:0] cnt_data,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  localparam int unsigned  DW      = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4
`ifdef ALLRED_EN
    ,
    AR_A = 3'd5,
    AR_B = 3'd6
`endif
  } state_t;

  state_t        state, succ;
  logic          legal;
  logic [DW-1:0] div_cnt;
  logic          en_q;

`ifndef ALLRED_EN
  logic [7:0] unused_allred;
  assign unused_allred = ALL_RED;
`endif

  function automatic logic [7:0] dur(input state_t s);
    case (s)
      NS_G:       dur = GREEN_NS;
      EW_G:       dur = GREEN_EW;
      NS_Y, EW_Y: dur = YELLOW;
`ifdef ALLRED_EN
      AR_A, AR_B: dur = ALL_RED;
`endif
      default:    dur = 8'h00;
    endcase
  endfunction

  // {ns, ew}, each {red, yellow, green}
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      NS_G:    lamps = 6'b001_100;
      NS_Y:    lamps = 6'b010_100;
      EW_G:    lamps = 6'b100_001;
      EW_Y:    lamps = 6'b100_010;
      default: lamps = 6'b100_100;
    endcase
  endfunction

  // Prescaler: a lost tick under hold is not replayed, the divider simply pauses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      en_q    <= 1'b0;
    end else if (hold) begin
      en_q    <= 1'b0;
    end else begin
      en_q    <= (div_cnt == DIV_MAX);
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
    end
  end

  assign cnt_en = en_q & ~hold;

  always_comb begin
    legal = 1'b1;
    succ  = INIT;
    case (state)
      INIT: succ = NS_G;
      NS_G: succ = NS_Y;
      EW_G: succ = EW_Y;
`ifdef ALLRED_EN
      NS_Y: succ = AR_A;
      AR_A: succ = EW_G;
      EW_Y: succ = AR_B;
      AR_B: succ = NS_G;
`else
      NS_Y: succ = EW_G;
      EW_Y: succ = NS_G;
`endif
      default: legal = 1'b0;
    endcase
  end

  assign cnt_load = (state == INIT) | cnt_zero;
  assign cnt_data = dur(succ);

  // State and counter reload share the same edge, so lamps track the loaded phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= INIT;
      {ns_light, ew_light} <= 6'b100_100;
    end else if (!legal) begin
      state                <= INIT;
      {ns_light, ew_light} <= lamps(INIT);
    end else if (cnt_en && cnt_load) begin
      state                <= succ;
      {ns_light, ew_light} <= lamps(succ);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a behavioural 2-digit BCD down-counter attached.
module tb_traffic_light_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic       cnt_zero, cnt_en, cnt_load;
  logic [7:0] cnt_data, cnt;
  logic [2:0] ns_light, ew_light;
  int total = 0, bad = 0, ec = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .CLK_DIV(4), .GREEN_NS(8'h03), .GREEN_EW(8'h02), .YELLOW(8'h01), .ALL_RED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .cnt_zero(cnt_zero), .cnt_en(cnt_en),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .ns_light(ns_light), .ew_light(ew_light)
  );

  // cnt10 stand-in: load has priority, BCD decrement, sticks at 00
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'h00;
    else if (cnt_en) begin
      if (cnt_load)            cnt <= cnt_data;
      else if (cnt[3:0] != 0)  cnt <= cnt - 8'd1;
      else if (cnt[7:4] != 0)  cnt <= {cnt[7:4] - 4'd1, 4'd9};
    end
  end
  assign cnt_zero = (cnt == 8'h00);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) chk("safe", {31'b0, ns_light[2] | ew_light[2]}, 32'd1);

  task automatic tick_to(input int e);
    while (ec < e) begin
      @(posedge clk);
      ec++;
    end
    @(negedge clk);
  endtask

  task automatic at(input int e, input string tag, input logic [2:0] ns, input logic [2:0] ew,
                    input logic [7:0] c);
    tick_to(e);
    chk({tag, ".ns"}, ns_light, ns);
    chk({tag, ".ew"}, ew_light, ew);
    chk({tag, ".cnt"}, cnt, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.ns", ns_light, 3'b100);
    chk("rst.ew", ew_light, 3'b100);
    chk("rst.en", cnt_en, 1'b0);

    rst = 1'b0;
    ec  = 0;
    tick_to(3);
    chk("t1.en_early", cnt_en, 1'b0);
    tick_to(4);
    chk("t1.en", cnt_en, 1'b1);
    chk("t1.load", cnt_load, 1'b1);
    chk("t1.data", cnt_data, 8'h03);
    chk("t1.ns_init", ns_light, 3'b100);
    at(5, "t1", 3'b001, 3'b100, 8'h03);
    chk("t1.en_off", cnt_en, 1'b0);

`ifdef ALLRED_EN
    at(21, "ns_y",   3'b010, 3'b100, 8'h01);
    at(28, "ns_y_e", 3'b010, 3'b100, 8'h00);
    chk("ns_y_e.data", cnt_data, 8'h01);
    at(29, "ar_a",   3'b100, 3'b100, 8'h01);
    at(36, "ar_a_e", 3'b100, 3'b100, 8'h00);
    at(37, "ew_g",   3'b100, 3'b001, 8'h02);
    at(49, "ew_y",   3'b100, 3'b010, 8'h01);
    at(57, "ar_b",   3'b100, 3'b100, 8'h01);
    at(64, "ar_b_e", 3'b100, 3'b100, 8'h00);
    at(65, "wrap",   3'b001, 3'b100, 8'h03);
    tick_to(70);
`else
    at(20, "ns_g_e", 3'b001, 3'b100, 8'h00);
    at(21, "ns_y",   3'b010, 3'b100, 8'h01);
    at(28, "ns_y_e", 3'b010, 3'b100, 8'h00);
    at(29, "ew_g",   3'b100, 3'b001, 8'h02);
    at(40, "ew_g_e", 3'b100, 3'b001, 8'h00);
    at(41, "ew_y",   3'b100, 3'b010, 8'h01);
    at(48, "ew_y_e", 3'b100, 3'b010, 8'h00);
    at(49, "wrap",   3'b001, 3'b100, 8'h03);

    // hold 20 clk in EW_G with counter at 01
    at(77, "hold_pre", 3'b100, 3'b001, 8'h01);
    hold = 1'b1;
    at(88, "hold_mid", 3'b100, 3'b001, 8'h01);
    chk("hold_mid.en", cnt_en, 1'b0);
    at(97, "hold_end", 3'b100, 3'b001, 8'h01);
    hold = 1'b0;
    tick_to(100);
    chk("resume.en", cnt_en, 1'b1);
    at(101, "resume1", 3'b100, 3'b001, 8'h00);
    at(104, "resume2", 3'b100, 3'b001, 8'h00);
    at(105, "ew_y2",   3'b100, 3'b010, 8'h01);

    // hold arrives with the tick that would end NS_G
    at(125, "ns_g2_e", 3'b001, 3'b100, 8'h00);
    tick_to(128);
    chk("pre_hold.en", cnt_en, 1'b1);
    hold = 1'b1;
    #1;
    chk("hold_same.en", cnt_en, 1'b0);
    at(131, "no_adv", 3'b001, 3'b100, 8'h00);
    hold = 1'b0;
    tick_to(134);
    chk("post_hold.en", cnt_en, 1'b0);
    tick_to(135);
    chk("late_tick.en", cnt_en, 1'b1);
    at(136, "adv", 3'b010, 3'b100, 8'h01);
    tick_to(138);
    chk("mid_ns_y.ns", ns_light, 3'b010);
`endif

    rst = 1'b1;
    #1;
    chk("rst_async.ns", ns_light, 3'b100);
    chk("rst_async.ew", ew_light, 3'b100);
    chk("rst_async.en", cnt_en, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ec  = 0;
    tick_to(3);
    chk("re.en_early", cnt_en, 1'b0);
    chk("re.cnt0", cnt, 8'h00);
    tick_to(4);
    chk("re.en", cnt_en, 1'b1);
    chk("re.data", cnt_data, 8'h03);
    at(5, "restart", 3'b001, 3'b100, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
